// File: rtl/morse_pkg.sv
// Shared Morse definitions for the encoder and decoder blocks.
package morse_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } morse_state_t;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_LINE = 1'b1;

    localparam int DOT_UNITS_DEF  = 1;
    localparam int LINE_UNITS_DEF = 3;
    localparam int GAP_UNITS_DEF  = 1;

endpackage

// File: rtl/morse_unit_timer.sv
// Emits a one-cycle unit_tick every UNIT_CYCLES clocks, counting from a clear.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    output logic unit_tick
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cur;

    // clear marks the first cycle of a new interval, which is count zero
    assign cur       = clear ? '0 : cnt;
    assign unit_tick = (cur == LAST);

    always_ff @(posedge clock) begin
        if (!resetn)
            cnt <= '0;
        else if (cur == LAST)
            cnt <= '0;
        else
            cnt <= cur + 1'b1;
    end

endmodule

// File: rtl/morse_encoder.sv
// Plays a latched Morse letter on morse_out with dot/line/gap timing in clock units.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int MAX_LEN     = 4,
    parameter int DOT_UNITS   = DOT_UNITS_DEF,
    parameter int LINE_UNITS  = LINE_UNITS_DEF,
    parameter int GAP_UNITS   = GAP_UNITS_DEF
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [MAX_LEN-1:0]           code,
    input  logic [$clog2(MAX_LEN+1)-1:0] code_len,
    output logic                         morse_out,
    output logic                         busy,
    output logic                         done
);

    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int MAXU = (LINE_UNITS > DOT_UNITS)
                        ? ((LINE_UNITS > GAP_UNITS) ? LINE_UNITS : GAP_UNITS)
                        : ((DOT_UNITS > GAP_UNITS) ? DOT_UNITS : GAP_UNITS);
    localparam int UW   = $clog2(MAXU + 1);

    morse_state_t       state;
    logic [MAX_LEN-1:0] sym;
    logic [LW-1:0]      idx;
    logic [LW-1:0]      len;
    logic [LW-1:0]      len_c;
    logic [UW-1:0]      units;
    logic [UW-1:0]      need;
    logic               clear;
    logic               tick;
    logic               last_unit;

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (clear),
        .unit_tick (tick)
    );

    assign len_c = (code_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : code_len;

    // The current symbol is always sym[0]; the register shifts once per symbol.
    always_comb begin
        need = UW'(GAP_UNITS);
        if (state == S_ON)
            need = (sym[0] == SYM_LINE) ? UW'(LINE_UNITS) : UW'(DOT_UNITS);
    end

    assign last_unit = tick && (units == need - 1'b1);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
            sym   <= '0;
            idx   <= '0;
            len   <= '0;
            units <= '0;
            clear <= 1'b0;
        end else begin
            clear <= 1'b0;
            case (state)
                S_IDLE: begin
                    units <= '0;
                    if (start) begin
                        sym   <= code;
                        len   <= len_c;
                        idx   <= '0;
                        clear <= 1'b1;
                        state <= (len_c == '0) ? S_DONE : S_ON;
                    end
                end
                S_ON: begin
                    if (last_unit) begin
                        units <= '0;
                        clear <= 1'b1;
                        state <= S_GAP;
                    end else if (tick) begin
                        units <= units + 1'b1;
                    end
                end
                S_GAP: begin
                    if (last_unit) begin
                        units <= '0;
                        clear <= 1'b1;
                        if (idx == len - 1'b1) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            sym   <= sym >> 1;
                            state <= S_ON;
                        end
                    end else if (tick) begin
                        units <= units + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign morse_out = (state == S_ON);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_morse_encoder.sv
// Directed table-driven bench for morse_encoder with UNIT_CYCLES=4.
module tb_morse_encoder;

    localparam int U = 4;

    logic       clock    = 1'b0;
    logic       resetn   = 1'b0;
    logic       start    = 1'b0;
    logic [3:0] code     = 4'b0;
    logic [2:0] code_len = 3'd0;
    logic       morse_out, busy, done;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [3:0] c;
        int         n;
        int         done_at;
        int         on_cyc;
        int         bs_at;
    } vec_t;

    vec_t vecs[9];

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .code      (code),
        .code_len  (code_len),
        .morse_out (morse_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic act, input logic exp_v, input int lbl);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s at t+%0d: got %b expected %b", name, lbl, act, exp_v);
        end
    endtask

    // Expected morse_out at label lbl (label 1 = first cycle after the start edge).
    function automatic logic exp_on(input logic [3:0] c, input int n, input int lbl);
        int pos = 1;
        int d;
        int m = (n > 4) ? 4 : n;
        for (int i = 0; i < m; i++) begin
            d = (c[i] ? 3 : 1) * U;
            if (lbl >= pos && lbl < pos + d) return 1'b1;
            pos += d + U;
        end
        return 1'b0;
    endfunction

    task automatic play(input logic [3:0] c, input int n, input int done_at,
                        input int on_exp, input int bs_at);
        int on_seen = 0;
        @(negedge clock);
        code     = c;
        code_len = 3'(n);
        start    = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= done_at + 3; k++) begin
            @(negedge clock);
            chk("morse_out", morse_out, exp_on(c, n, k), k);
            chk("done", done, (k == done_at), k);
            chk("busy", busy, (k <= done_at), k);
            if (morse_out) on_seen++;
            if (k == bs_at) begin
                start    = 1'b1;
                code     = 4'b1111;
                code_len = 3'd4;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (on_seen != on_exp) begin
            fails++;
            $display("FAIL on_cycles code=%b len=%0d: got %0d expected %0d", c, n, on_seen, on_exp);
        end
    endtask

    initial begin
        vecs[0] = '{4'b0010, 2, 25, 16, -1};  // A
        vecs[1] = '{4'b0111, 3, 49, 36, -1};  // O
        vecs[2] = '{4'b0010, 2, 25, 16,  6};  // A with start while busy
        vecs[3] = '{4'b0000, 0,  1,  0, -1};  // empty letter
        vecs[4] = '{4'b0000, 7, 33, 16, -1};  // clamped to four dots
        vecs[5] = '{4'b0001, 1, 17, 12, -1};  // T
        vecs[6] = '{4'b0000, 1,  9,  4, -1};  // E
        vecs[7] = '{4'b1011, 4, 57, 40, -1};  // line line dot line
        vecs[8] = '{4'b1110, 2, 25, 16, -1};  // A with don't-care upper bits

        // Reset held with start asserted
        resetn   = 1'b0;
        start    = 1'b1;
        code     = 4'b0010;
        code_len = 3'd2;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            chk("rst_morse_out", morse_out, 1'b0, k);
            chk("rst_busy", busy, 1'b0, k);
            chk("rst_done", done, 1'b0, k);
        end
        resetn = 1'b1;
        start  = 1'b0;
        @(negedge clock);
        chk("post_rst_morse_out", morse_out, 1'b0, 4);
        chk("post_rst_busy", busy, 1'b0, 4);
        chk("post_rst_done", done, 1'b0, 4);

        for (int v = 0; v < 9; v++)
            play(vecs[v].c, vecs[v].n, vecs[v].done_at, vecs[v].on_cyc, vecs[v].bs_at);

        // Reset in the middle of the 'A' line, then a clean replay
        @(negedge clock);
        code     = 4'b0010;
        code_len = 3'd2;
        start    = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            start = 1'b0;
            chk("mid_morse_out", morse_out, exp_on(4'b0010, 2, k), k);
            chk("mid_busy", busy, 1'b1, k);
        end
        resetn = 1'b0;
        @(negedge clock);
        chk("mid_rst_morse_out", morse_out, 1'b0, 11);
        chk("mid_rst_busy", busy, 1'b0, 11);
        chk("mid_rst_done", done, 1'b0, 11);
        resetn = 1'b1;
        play(4'b0010, 2, 25, 16, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
